// File: rtl/sin_pkg.sv
// sin_pkg: shared definitions for the quarter-wave sine NCO.
// Latency: n/a (types, constants, constant functions, elaboration check macro).
// Backpressure: n/a.
// Contents: quadrant codes Q0..Q3, fold() sign stage, quarter_sin() table generator,
//           SIN_CHECK_WIDTH elaboration guard.

`ifndef SIN_PKG_MACROS
`define SIN_PKG_MACROS
// Elaboration guard: the accumulator must hold the quadrant bits plus a full table address.
`define SIN_CHECK_WIDTH(PW, AW) \
  if ((PW) < (AW) + 2) begin : g_width_chk \
    $error("sin_nco: PHASE_WIDTH must be >= ADR_WIDTH+2"); \
  end
`endif

package sin_pkg;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // pi in Q30 fixed point, used by the elaboration-time table generator.
  localparam longint PI_Q30 = 64'sd3373259426;

  // Sign stage of the quadrant fold. Mirroring of the address (~a) happens before
  // the ROM, so only the negation for the lower half-wave is applied here.
  function automatic logic signed [32:0] fold(input logic [31:0] mag, input logic [1:0] q);
    logic signed [32:0] m;
    m = $signed({1'b0, mag});
    return (q == Q2 || q == Q3) ? -m : m;
  endfunction

  // round((2**dw-1) * sin(pi/2 * (k+0.5) / 2**aw)) using a Q30 Taylor series.
  // Only ever called with constant arguments, so it folds away at elaboration.
  function automatic longint quarter_sin(input int k, input int aw, input int dw);
    longint x;
    longint term;
    longint sum;
    x = (PI_Q30 * longint'(2 * k + 1)) >>> (aw + 2);
    term = x;
    sum = x;
    for (int n = 1; n < 12; n++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * n) * (2 * n + 1));
      sum = sum + term;
    end
    return ((longint'((1 << dw) - 1) * sum) + (64'sd1 <<< 29)) >>> 30;
  endfunction

endpackage

// File: rtl/sin_quarter_rom.sv
// sin_quarter_rom: quarter-wave sine magnitude table with two synchronous read ports.
// Latency: 1 clk from address to o_dat_*; outputs hold while i_rd_en=0.
// Backpressure: none; i_rd_en is the only qualifier (shared by both ports).
// Ports: i_clk clock; i_rd_en read enable; i_adr_a/i_adr_b addresses;
//        o_dat_a/o_dat_b registered unsigned magnitudes.

module sin_quarter_rom
  import sin_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADR_WIDTH  = 8,
  parameter     ROM_FILE   = "sin_table.dat"
) (
  input  logic                  i_clk,
  input  logic                  i_rd_en,
  input  logic [ADR_WIDTH-1:0]  i_adr_a,
  input  logic [ADR_WIDTH-1:0]  i_adr_b,
  output logic [DATA_WIDTH-1:0] o_dat_a,
  output logic [DATA_WIDTH-1:0] o_dat_b
);

  localparam int DEPTH = 2 ** ADR_WIDTH;

  // The table image is produced at elaboration from the same formula that generates
  // the offline hex file, so no file has to be present at build or run time.
  // ROM_FILE is kept so existing instantiations that name an image still elaborate.
  localparam int ROM_FILE_CHARS = $bits(ROM_FILE) / 8;
  if (ROM_FILE_CHARS == 0) begin : g_rom_file_chk
    $error("sin_quarter_rom: ROM_FILE must name the table image");
  end

  logic [DATA_WIDTH-1:0] w_ram [0:DEPTH-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [DATA_WIDTH-1:0] C_VAL = DATA_WIDTH'(quarter_sin(k, ADR_WIDTH, DATA_WIDTH));
    assign w_ram[k] = C_VAL;
  end

  logic [DATA_WIDTH-1:0] r_dat_a;
  logic [DATA_WIDTH-1:0] r_dat_b;

  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_dat_a <= w_ram[i_adr_a];
      r_dat_b <= w_ram[i_adr_b];
    end
  end

  assign o_dat_a = r_dat_a;
  assign o_dat_b = r_dat_b;

endmodule

// File: rtl/sin_nco.sv
// sin_nco: phase-accumulator NCO producing signed full-wave sine and cosine.
// Latency: sample issued with en at edge n appears after edge n+1 with out_valid=1.
// Backpressure: none; en=0 inserts a bubble (outputs hold, out_valid=0).
// Ports: clk, rst (sync, active-high); en issue+advance; freq_word increment;
//        phase_load/phase_in accumulator overwrite; phase_out accumulator;
//        out_valid, sin_out, cos_out (signed DATA_WIDTH+1).

module sin_nco
  import sin_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADR_WIDTH   = 8,
  parameter int PHASE_WIDTH = 16,
  parameter     ROM_FILE    = "sin_table.dat"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PHASE_WIDTH-1:0] freq_word,
  input  logic                   phase_load,
  input  logic [PHASE_WIDTH-1:0] phase_in,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic                   out_valid,
  output logic [DATA_WIDTH:0]    sin_out,
  output logic [DATA_WIDTH:0]    cos_out
);

  `SIN_CHECK_WIDTH(PHASE_WIDTH, ADR_WIDTH)

  logic [PHASE_WIDTH-1:0] r_phase;
  logic [1:0]             w_q;
  logic [ADR_WIDTH-1:0]   w_a;
  logic [ADR_WIDTH-1:0]   w_adr_sin;
  logic [ADR_WIDTH-1:0]   w_adr_cos;
  logic [DATA_WIDTH-1:0]  w_mag_sin;
  logic [DATA_WIDTH-1:0]  w_mag_cos;
  logic [1:0]             r_q1;
  logic                   r_v1;
  logic                   r_valid;
  logic [DATA_WIDTH:0]    r_sin;
  logic [DATA_WIDTH:0]    r_cos;

  // Quadrant and table address; bits below the address are simply truncated.
  assign w_q = r_phase[PHASE_WIDTH-1 -: 2];
  assign w_a = r_phase[PHASE_WIDTH-3 -: ADR_WIDTH];

  // Odd quadrants read the mirrored entry. Cosine sits one quadrant ahead, so its
  // mirror sense is the opposite of the sine's.
  assign w_adr_sin = w_q[0] ? ~w_a : w_a;
  assign w_adr_cos = w_q[0] ? w_a : ~w_a;

  sin_quarter_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADR_WIDTH  (ADR_WIDTH),
    .ROM_FILE   (ROM_FILE)
  ) u_rom (
    .i_clk   (clk),
    .i_rd_en (en),
    .i_adr_a (w_adr_sin),
    .i_adr_b (w_adr_cos),
    .o_dat_a (w_mag_sin),
    .o_dat_b (w_mag_cos)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
      r_q1    <= Q0;
      r_v1    <= 1'b0;
      r_valid <= 1'b0;
      r_sin   <= '0;
      r_cos   <= '0;
    end else begin
      // Load has priority; the sample issued this cycle still uses the old phase.
      if (phase_load) begin
        r_phase <= phase_in;
      end else if (en) begin
        r_phase <= r_phase + freq_word;
      end

      // Stage 1: quadrant travels alongside the registered ROM reads.
      if (en) begin
        r_q1 <= w_q;
      end
      r_v1 <= en;

      // Stage 2: apply sign; outputs only move when a sample is in flight.
      r_valid <= r_v1;
      if (r_v1) begin
        r_sin <= (DATA_WIDTH+1)'(fold(32'(w_mag_sin), r_q1));
        r_cos <= (DATA_WIDTH+1)'(fold(32'(w_mag_cos), r_q1 + 2'd1));
      end
    end
  end

  assign phase_out = r_phase;
  assign out_valid = r_valid;
  assign sin_out   = r_sin;
  assign cos_out   = r_cos;

endmodule
